// File: rtl/fp_addsub_seq.sv
// rtl/fp_addsub_seq.sv - multi-cycle handshaked floating-point add/subtract unit
//
// Purpose:
//   Computes a+b or a-b on {sign, exp, frac} operands with round-to-nearest-even.
//   Denormal inputs are flushed to zero, overflow saturates to infinity and
//   results whose exponent falls to zero or below are flushed to signed zero.
//   Left normalisation runs one bit per cycle, so latency is 4 + k cycles
//   from the accept edge, where k is the number of left shifts.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   operands valid           in_ready   unit idle, can accept
//   op_sub     0: a+b, 1: a-b           a, b       operands
//   out_valid  result valid             out_ready  consumer takes result
//   result     rounded result
//   overflow   result saturated to infinity
//   underflow  nonzero result flushed to zero

module fp_addsub_seq #(
  parameter  int EXP_W  = 8,
  parameter  int FRAC_W = 23,
  localparam int W      = EXP_W + FRAC_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         underflow
);

  // Working significand: {carry, hidden, frac, guard, round, sticky}
  localparam int SW = FRAC_W + 5;
  // Signed working exponent, wide enough for carry growth and underrun
  localparam int EW = EXP_W + 2;
  // Alignment distance beyond which the smaller operand is sticky only
  localparam logic [31:0] SHIFT_MAX = 32'(FRAC_W + 3);

  localparam logic [EXP_W-1:0]    EXP_ONES = {EXP_W{1'b1}};
  localparam logic signed [EW-1:0] EXP_MAX = {2'b00, EXP_ONES};
  localparam logic signed [EW-1:0] EXP_INC = 1;
  localparam logic [W-1:0]        QNAN     = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_ROUND = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]             state;
  logic [W-1:0]           a_r;
  logic [W-1:0]           b_r;            // sign already holds b.sign ^ op_sub
  logic                   sign_r;
  logic                   sub_r;
  logic                   special_r;
  logic [W-1:0]           special_val_r;
  logic signed [EW-1:0]   exp_r;
  logic [SW-1:0]          sig_r;
  logic [SW-1:0]          sig_b_r;

  // ---------------------------------------------------------------------
  // Alignment: classify, order by magnitude, shift the smaller operand
  // ---------------------------------------------------------------------
  logic [EXP_W-1:0]  exp_a, exp_b, big_exp, small_exp, exp_diff;
  logic [FRAC_W-1:0] frac_a, frac_b;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [W-2:0]      key_a, key_b;
  logic              swap, big_sign, lost;
  logic [SW-1:0]     sig_a, sig_b, big_sig, small_sig, shifted, aligned;
  logic              spec_hit;
  logic [W-1:0]      spec_val;

  always_comb begin
    exp_a  = a_r[W-2:FRAC_W];
    exp_b  = b_r[W-2:FRAC_W];
    frac_a = a_r[FRAC_W-1:0];
    frac_b = b_r[FRAC_W-1:0];
    a_zero = (exp_a == '0);
    b_zero = (exp_b == '0);
    a_inf  = (exp_a == EXP_ONES) && (frac_a == '0);
    b_inf  = (exp_b == EXP_ONES) && (frac_b == '0);
    a_nan  = (exp_a == EXP_ONES) && (frac_a != '0);
    b_nan  = (exp_b == EXP_ONES) && (frac_b != '0);

    // Denormals compare as zero so they never win the swap
    key_a = a_zero ? '0 : a_r[W-2:0];
    key_b = b_zero ? '0 : b_r[W-2:0];
    sig_a = a_zero ? '0 : {2'b01, frac_a, 3'b000};
    sig_b = b_zero ? '0 : {2'b01, frac_b, 3'b000};
    swap  = (key_b > key_a);

    big_sig   = swap ? sig_b : sig_a;
    small_sig = swap ? sig_a : sig_b;
    big_exp   = swap ? exp_b : exp_a;
    small_exp = swap ? exp_a : exp_b;
    big_sign  = swap ? b_r[W-1] : a_r[W-1];

    exp_diff = big_exp - small_exp;
    shifted  = small_sig >> exp_diff;
    // Any bit that fell off the bottom shows up as a mismatch on the way back
    lost     = ((shifted << exp_diff) != small_sig);
    if (32'(exp_diff) >= SHIFT_MAX) begin
      aligned = {{(SW-1){1'b0}}, |small_sig};
    end else begin
      aligned = shifted | {{(SW-1){1'b0}}, lost};
    end

    spec_hit = a_nan | b_nan | a_inf | b_inf;
    if (a_nan || b_nan || (a_inf && b_inf && (a_r[W-1] != b_r[W-1]))) begin
      spec_val = QNAN;
    end else if (a_inf) begin
      spec_val = {a_r[W-1], EXP_ONES, {FRAC_W{1'b0}}};
    end else begin
      spec_val = {b_r[W-1], EXP_ONES, {FRAC_W{1'b0}}};
    end
  end

  // ---------------------------------------------------------------------
  // Rounding and final packing from the normalised significand
  // ---------------------------------------------------------------------
  logic [FRAC_W:0]      mant;
  logic [FRAC_W+1:0]    mant_rnd;
  logic [FRAC_W:0]      mant_norm;
  logic                 rnd_up, rnd_carry;
  logic signed [EW-1:0] exp_rnd;
  logic [W-1:0]         res_next;
  logic                 ovf_next, unf_next;

  always_comb begin
    mant      = sig_r[SW-2:3];
    rnd_up    = sig_r[2] & (sig_r[1] | sig_r[0] | mant[0]);
    mant_rnd  = {1'b0, mant} + {{(FRAC_W+1){1'b0}}, rnd_up};
    rnd_carry = mant_rnd[FRAC_W+1];
    mant_norm = rnd_carry ? mant_rnd[FRAC_W+1:1] : mant_rnd[FRAC_W:0];
    exp_rnd   = rnd_carry ? (exp_r + EXP_INC) : exp_r;

    ovf_next = 1'b0;
    unf_next = 1'b0;
    if (special_r) begin
      res_next = special_val_r;
    end else if (!mant_norm[FRAC_W]) begin
      // Normalisation leaves the hidden bit set unless the sum was exactly zero
      res_next = '0;
    end else if (exp_rnd[EW-1] || (exp_rnd == '0)) begin
      res_next = {sign_r, {(W-1){1'b0}}};
      unf_next = 1'b1;
    end else if (exp_rnd >= EXP_MAX) begin
      res_next = {sign_r, EXP_ONES, {FRAC_W{1'b0}}};
      ovf_next = 1'b1;
    end else begin
      res_next = {sign_r, exp_rnd[EXP_W-1:0], mant_norm[FRAC_W-1:0]};
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      result        <= '0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      a_r           <= '0;
      b_r           <= '0;
      sign_r        <= 1'b0;
      sub_r         <= 1'b0;
      special_r     <= 1'b0;
      special_val_r <= '0;
      exp_r         <= '0;
      sig_r         <= '0;
      sig_b_r       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r       <= a;
            b_r       <= {b[W-1] ^ op_sub, b[W-2:0]};
            overflow  <= 1'b0;
            underflow <= 1'b0;
            state     <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          sign_r        <= big_sign;
          sub_r         <= a_r[W-1] ^ b_r[W-1];
          exp_r         <= {2'b00, big_exp};
          sig_r         <= big_sig;
          sig_b_r       <= aligned;
          special_r     <= spec_hit;
          special_val_r <= spec_val;
          state         <= S_ADD;
        end
        S_ADD: begin
          // Swap guarantees the first operand is not smaller, so no borrow out
          sig_r <= sub_r ? (sig_r - sig_b_r) : (sig_r + sig_b_r);
          state <= S_NORM;
        end
        S_NORM: begin
          if (special_r) begin
            state <= S_ROUND;
          end else if (sig_r[SW-1]) begin
            // Carry out: shift right once, the dropped bit joins sticky
            sig_r <= {1'b0, sig_r[SW-1:2], sig_r[1] | sig_r[0]};
            exp_r <= exp_r + EXP_INC;
            state <= S_ROUND;
          end else if (!sig_r[SW-2] && (sig_r != '0)) begin
            sig_r <= {sig_r[SW-2:0], 1'b0};
            exp_r <= exp_r - EXP_INC;
          end else begin
            state <= S_ROUND;
          end
        end
        S_ROUND: begin
          result    <= res_next;
          overflow  <= ovf_next;
          underflow <= unf_next;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

endmodule

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
Multi-cycle, handshaked floating-point add/subtract unit, parametrised in exponent and fraction width. Successor to the single-precision combinational subtractor.
- Adds a runtime add/sub mode, valid/ready flow control and round-to-nearest-even.
- Handles zero, infinity, overflow and underflow.
- Normalises iteratively, one bit per cycle, under an FSM.
- Sits in the ALU datapath beside the other FP operators.

Parameters:
EXP_W, 8, exponent field width
FRAC_W, 23, stored fraction width (hidden bit implicit)
W, EXP_W+FRAC_W+1, derived operand/result width (localparam, not overridable)

Ports:
clk  input  1  clock; only clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  operands valid
in_ready  output  1  unit can accept operands
op_sub  input  1  0: a+b, 1: a-b; sampled with operands
a  input  W  operand A {sign, exp, frac}
b  input  W  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  W  rounded result
overflow  output  1  result saturated to infinity
underflow  output  1  nonzero result flushed to zero

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: out_valid=0, in_ready=1, result=0, overflow=0, underflow=0, FSM=IDLE. Reset wins over every other event in the same cycle.
- Reset mid-operation: the in-flight operation is discarded and no output is produced.
- States: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture a, b, op_sub. Effective sign of b = b.sign^op_sub. Go to ALIGN.
- ALIGN, 1 cycle:
  - Exp=0 inputs are treated as zero (denormals flushed).
  - Swap so the larger magnitude is the first operand; result sign = its sign.
  - Right-shift the smaller significand by the exponent difference, keeping guard, round and sticky bits.
  - Difference ≥ FRAC_W+3 reduces the smaller operand to sticky only.
- ADD, 1 cycle: add significands if effective signs match, else subtract (never negative, because of the swap).
- NORM:
  - On carry-out: shift right 1, exp+1, fold the lost bit into sticky; then go to ROUND.
  - Otherwise: while MSB=0 and the significand is nonzero, shift left 1 and decrement exp, one bit per cycle.
  - Exact zero sum: result +0, go to ROUND.
- ROUND, 1 cycle:
  - Round to nearest even on guard/round/sticky.
  - A rounding carry renormalises and increments exp.
- Overflow: exp ≥ 2^EXP_W−1 → result = ±inf, overflow=1.
- Underflow: exp reaching 0 with a nonzero significand → ±0, underflow=1.
- DONE: out_valid=1, in_ready=0. result and flags stay stable until out_ready. The handshake returns to IDLE; the next accept happens in IDLE, with no same-cycle turnaround.
- Latency: accept edge to out_valid = 4 + k cycles, where k is the number of left-normalisation shifts (0..FRAC_W+3).
- Specials:
  - Any operand with exp all-ones and frac=0 gives that infinity.
  - inf − inf gives canonical qNaN {0, all-ones, 1, zeros}.
  - NaN inputs give canonical qNaN.
  - Flags stay 0 for all special cases.
- Flags are valid only while out_valid=1 and are cleared on the IDLE accept.

Test Plan:
1. a=0x40400000, b=0x3F800000, op_sub=1 → result 0x40000000, flags 0, out_valid 4 cycles after accept.
2. a=0x3F800000, b=0x3F7FFFFF, op_sub=1 → 0x33800000 after 24 left shifts (out_valid 28 cycles after accept). Also a=0x40A00000, b=0x40A00000, op_sub=1 → 0x00000000.
3. a=0x3F800000, b=0x33800000, op_sub=0 (tie) → 0x3F800000 (round to even). b=0x33C00000 → 0x3F800001.
4. a=b=0x7F7FFFFF, op_sub=0 → 0x7F800000, overflow=1. a=0x00800000, b=0x00800001, op_sub=1 → 0x80000000, underflow=1.
5. Hold out_ready=0 for 5 cycles after out_valid and present new operands meanwhile → result stable, in_ready=0, new operands accepted only in the cycle after the handshake.
6. Assert rst for 1 cycle during NORM of case 2 → next cycle out_valid=0, in_ready=1, no result emitted. A following case 1 completes correctly. Also a=0x7F800000, b=0x7F800000, op_sub=1 → 0x7FC00000.
